// File: rtl/spi_cmd_pkg.sv
// Shared encodings for the SPI command sequencer: opcodes, error codes, FSM states, frame layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_cmd_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_CLEAR = 2'b10,
    OP_BCAST = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_LEN     = 3'd1,
    ERR_TARGET  = 3'd2,
    ERR_OVERRUN = 3'd3,
    ERR_TIMEOUT = 3'd4
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_ISSUE  = 2'd2
  } state_e;

  // Frame field positions within the 32-bit SPI word
  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 30;
  localparam int TGT_MSB  = 29;
  localparam int TGT_LSB  = 26;
  localparam int REG_MSB  = 25;
  localparam int REG_LSB  = 24;
  localparam int DATA_MSB = 23;
  localparam int DATA_LSB = 0;

  localparam logic [5:0] FRAME_BITS    = 6'd32;
  localparam logic [5:0] BIT_COUNT_MAX = 6'd63;

  // Packed view of a frame; field order matches the positions above (MSB first)
  typedef struct packed {
    logic [1:0]  op;
    logic [3:0]  target;
    logic [1:0]  rsel;
    logic [23:0] data;
  } cmd_t;

  // 8-bit add that sticks at 255 instead of wrapping
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] n);
    logic [8:0] s;
    s = {1'b0, a} + {7'd0, n};
    return (s > 9'd255) ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/spi_frame_counter.sv
// Tracks SS_N edges, counts SCLK rising edges within a frame and flags the frame end.
// Latency: frame_end is combinational in the first cycle ss_n_sync reads 1 after 0; bit_count updates one cycle after each pulse.
// Backpressure: none; free-running observer of the SPI pins.
module spi_frame_counter
  import spi_cmd_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ss_n_sync,
  input  logic       sclk_rise,
  output logic [5:0] bit_count,
  output logic       frame_end
);

  logic ss_d;
  logic ss_fall;

  assign ss_fall   = ss_d & ~ss_n_sync;
  assign frame_end = ~ss_d & ss_n_sync;

  // Delayed copy of SS_N; resets to idle-high so reset release never looks like a frame end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ss_d <= 1'b1;
    else          ss_d <= ss_n_sync;
  end

  // Bit counter: restart at frame start, count SCLK edges while selected, stick at the maximum
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_count <= 6'd0;
    end else if (ss_fall) begin
      bit_count <= 6'd0;
    end else if (sclk_rise && !ss_n_sync && bit_count != BIT_COUNT_MAX) begin
      bit_count <= bit_count + 6'd1;
    end
  end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Decodes completed SPI frames into register writes (single or broadcast) and keeps status counters.
// Latency: frame end at T -> DECODE at T+1 -> wr_valid at T+2; next broadcast write one cycle after each handshake.
// Backpressure: wr_valid holds with stable payload until wr_ready; aborts after TIMEOUT_CYCLES without a handshake.
module spi_cmd_sequencer
  import spi_cmd_pkg::*;
#(
  parameter int NUM_TARGETS    = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ss_n_sync,
  input  logic        sclk_rise,
  input  logic [31:0] spi_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [3:0]  wr_target,
  output logic [1:0]  wr_reg,
  output logic [23:0] wr_data,
  output logic        busy,
  output logic [31:0] status_word
);

  localparam logic [4:0] NT          = 5'(NUM_TARGETS);
  localparam logic [3:0] LAST_TARGET = 4'(NUM_TARGETS - 1);
  localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT_CYCLES - 1);

  state_e      state;
  cmd_t        cmd;
  logic [7:0]  tmo_cnt;
  logic [5:0]  bit_count;
  logic        frame_end;

  logic [7:0]  frame_count;
  logic [7:0]  err_count;
  logic [2:0]  err_code;

  logic        hs;
  logic        last_write;
  logic        overrun;
  logic        len_err;
  logic        tgt_err;
  logic        tmo_err;
  logic        fsm_err;
  logic [2:0]  fsm_code;
  logic        frame_inc;
  logic        clr_stat;
  logic        start_issue;

  spi_frame_counter u_frame_counter (
    .clock     (clock),
    .reset_n   (reset_n),
    .ss_n_sync (ss_n_sync),
    .sclk_rise (sclk_rise),
    .bit_count (bit_count),
    .frame_end (frame_end)
  );

  assign hs          = wr_valid & wr_ready;
  assign overrun     = frame_end & (state != ST_IDLE);
  assign last_write  = (cmd.op == OP_WRITE) || (wr_target == LAST_TARGET);
  assign busy        = (state != ST_IDLE);
  assign status_word = {err_code, 5'b0, err_count, frame_count, 2'b0, bit_count};

  // Per-cycle events: decode verdicts, completion, timeout, and the error code they imply
  always_comb begin
    len_err     = 1'b0;
    tgt_err     = 1'b0;
    tmo_err     = 1'b0;
    frame_inc   = 1'b0;
    clr_stat    = 1'b0;
    start_issue = 1'b0;
    case (state)
      ST_DECODE: begin
        if (bit_count != FRAME_BITS) begin
          len_err = 1'b1;
        end else if (cmd.op == OP_WRITE && {1'b0, cmd.target} >= NT) begin
          tgt_err = 1'b1;
        end else if (cmd.op == OP_NOP) begin
          frame_inc = 1'b1;
        end else if (cmd.op == OP_CLEAR) begin
          clr_stat = 1'b1;
        end else begin
          start_issue = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (hs) frame_inc = last_write;
        else if (tmo_cnt == TMO_LAST) tmo_err = 1'b1;
      end
      default: ;
    endcase
    fsm_err  = len_err | tgt_err | tmo_err;
    fsm_code = len_err ? ERR_LEN : (tgt_err ? ERR_TARGET : ERR_TIMEOUT);
  end

  // Main FSM with registered write-port outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cmd       <= '0;
      tmo_cnt   <= 8'd0;
      wr_valid  <= 1'b0;
      wr_target <= 4'd0;
      wr_reg    <= 2'd0;
      wr_data   <= 24'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_end) begin
            cmd   <= spi_data;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (start_issue) begin
            state     <= ST_ISSUE;
            wr_valid  <= 1'b1;
            tmo_cnt   <= 8'd0;
            wr_reg    <= cmd.rsel;
            wr_data   <= cmd.data;
            wr_target <= (cmd.op == OP_BCAST) ? 4'd0 : cmd.target;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (hs) begin
            tmo_cnt <= 8'd0;
            if (last_write) begin
              wr_valid <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              wr_target <= wr_target + 4'd1;
            end
          end else if (tmo_err) begin
            wr_valid <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Status counters; an overrun in the same cycle as another event still counts and owns the code
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= 8'd0;
      err_count   <= 8'd0;
      err_code    <= ERR_NONE;
    end else begin
      if (clr_stat)       frame_count <= 8'd0;
      else if (frame_inc) frame_count <= sat_add8(frame_count, 2'd1);

      err_count <= sat_add8(clr_stat ? 8'd0 : err_count, 2'(fsm_err) + 2'(overrun));

      if (overrun)       err_code <= ERR_OVERRUN;
      else if (fsm_err)  err_code <= fsm_code;
      else if (clr_stat) err_code <= ERR_NONE;
    end
  end

endmodule
